// File: rtl/cs_pkg.sv
// cs_pkg: shared types for the cs_decode_ovl device-select decoder.
// Bank nibble constants, overlay state enum, latched select bundle.
package cs_pkg;

  localparam logic [3:0] IACK_BANK  = 4'hF;
  localparam logic [3:0] VIA_BANK   = 4'hE;
  localparam logic [3:0] IWM_BANK   = 4'hD;
  localparam logic [3:0] SCC_W_BANK = 4'hB;
  localparam logic [3:0] SCC_R_BANK = 4'h9;
  localparam logic [3:0] SCSI_BANK  = 4'h5;
  localparam logic [3:0] CNT_MAX    = 4'hF;

  typedef enum logic [1:0] {
    OVL,
    COUNT,
    NORM
  } ovl_state_t;

  // vid_pg/snd_pg are the page hits without nWE; the
  // write qualification is always applied live.
  typedef struct packed {
    logic romcs4x;
    logic ramcs0x;
    logic romcs;
    logic ramcs;
    logic iacs;
    logic io_base;
    logic vid_pg;
    logic snd_pg;
    logic overlay;
  } sel_t;

  function automatic logic [3:0] cnt_inc(
    input logic [3:0] c
  );
    return (c == CNT_MAX) ? c : c + 4'd1;
  endfunction

endpackage

// File: rtl/cs_decode_ovl_if.sv
// cs_decode_ovl_if: CPU bus inputs and device selects of the decoder.
// master = CPU/bench side, slave = decoder side.
interface cs_decode_ovl_if #(
  parameter int AW = 24
);
  logic [AW-9:0] A;
  logic          nWE;
  logic          BACT;
  logic          IOCS;
  logic          IOPWCS;
  logic          IACS;
  logic          ROMCS;
  logic          ROMCS4X;
  logic          RAMCS;
  logic          RAMCS0X;
  logic          SndRAMCSWR;
  logic          Overlay;
  logic          ROMWERR;

  modport master (
    output A, nWE, BACT,
    input  IOCS, IOPWCS, IACS, ROMCS, ROMCS4X,
    input  RAMCS, RAMCS0X, SndRAMCSWR, Overlay,
    input  ROMWERR
  );

  modport slave (
    input  A, nWE, BACT,
    output IOCS, IOPWCS, IACS, ROMCS, ROMCS4X,
    output RAMCS, RAMCS0X, SndRAMCSWR, Overlay,
    output ROMWERR
  );
endinterface

// File: rtl/cs_overlay_fsm.sv
// cs_overlay_fsm: counted boot overlay (OVL -> COUNT -> NORM).
// In: CLK, nRES, BACT, rom_hit. Out: Overlay, cnt, ovl_d (next Overlay).
module cs_overlay_fsm
  import cs_pkg::*;
#(
  parameter int OVL_EXIT_COUNT = 1
) (
  input  logic       CLK,
  input  logic       nRES,
  input  logic       BACT,
  input  logic       rom_hit,
  output logic       Overlay,
  output logic [3:0] cnt,
  output logic       ovl_d
);

  localparam logic [3:0] EXIT_CNT = 4'(OVL_EXIT_COUNT);

  ovl_state_t state_q;
  logic       bact_q;
  logic       ovl_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       hit;
  logic       leave;

  // rom_hit is the latched select of the cycle that just ended
  assign hit   = (state_q != NORM) && bact_q
              && !BACT && rom_hit;
  assign cnt_d = hit ? cnt_inc(cnt_q) : cnt_q;
  // Exit only while the bus is idle so Overlay is stable in a cycle
  assign leave = (state_q != NORM) && !BACT
              && (cnt_d >= EXIT_CNT);
  assign ovl_d = ovl_q && !leave;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q <= OVL;
      bact_q  <= 1'b0;
      cnt_q   <= 4'd0;
      ovl_q   <= 1'b1;
    end else begin
      bact_q <= BACT;
      cnt_q  <= cnt_d;
      ovl_q  <= ovl_d;
      if (leave) begin
        state_q <= NORM;
      end else if (hit) begin
        state_q <= COUNT;
      end
    end
  end

  assign Overlay = ovl_q;
  assign cnt     = cnt_q;

endmodule

// File: rtl/cs_decode_ovl.sv
// cs_decode_ovl: A[AW-1:8] device-select decoder, selects held per bus cycle.
// Ports: CLK, nRES, bus (slave). Optional macro CS_ROMWP_EN: ROM write protect.
module cs_decode_ovl
  import cs_pkg::*;
#(
  parameter int          AW             = 24,
  parameter logic [3:0]  ROM_BANK       = 4'h4,
  parameter int          OVL_EXIT_COUNT = 1,
  parameter logic [15:0] VID_PAGE_MASK  = 16'hFCFC,
  parameter logic [15:0] SND_PAGE_MASK  = 16'h8400
) (
  input  logic            CLK,
  input  logic            nRES,
  cs_decode_ovl_if.slave  bus
);

  function automatic sel_t decode(
    input logic [AW-9:0] a,
    input logic          ovl
  );
    sel_t       s;
    logic [3:0] n;
    logic       top;
    n         = a[AW-9 -: 4];
    s.romcs4x = (n == ROM_BANK);
    s.ramcs0x = (a[AW-9 -: 2] == 2'b00);
    s.romcs   = ((n == 4'h0) && ovl) || s.romcs4x;
    s.ramcs   = s.ramcs0x && !ovl;
    // top 64k of the RAM banks
    top       = s.ramcs && (n[1:0] == 2'b11)
             && (&a[AW-13:8]);
    s.vid_pg  = top && VID_PAGE_MASK[a[7:4]];
    s.snd_pg  = top && SND_PAGE_MASK[a[7:4]];
    s.iacs    = (n == IACK_BANK)
             && (a[AW-13 -: 2] == 2'b11);
    s.io_base = (n >= SCSI_BANK) || (s.romcs4x && ovl);
    s.overlay = ovl;
    return s;
  endfunction

  logic       ovl;
  logic       ovl_d;
  logic [3:0] ovl_cnt;
  logic       rom_hit;
  logic       rom_blk;
  logic       wr;
  logic       vidwr;
  logic       sel_vld_q;
  sel_t       raw;
  sel_t       nxt;
  sel_t       sel_q;
  sel_t       cur;
  logic       unused_cnt;

  cs_overlay_fsm #(
    .OVL_EXIT_COUNT (OVL_EXIT_COUNT)
  ) u_fsm (
    .CLK     (CLK),
    .nRES    (nRES),
    .BACT    (bus.BACT),
    .rom_hit (rom_hit),
    .Overlay (ovl),
    .cnt     (ovl_cnt),
    .ovl_d   (ovl_d)
  );

  assign unused_cnt = ^ovl_cnt;

  assign raw = decode(bus.A, ovl);
  // Latch with the Overlay the next cycle will actually run under
  assign nxt = decode(bus.A, ovl_d);

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
    end else if (!bus.BACT) begin
      sel_q     <= nxt;
      sel_vld_q <= 1'b1;
    end
  end

  // A cycle already running when reset lifts has no latch yet
  assign cur   = (bus.BACT && sel_vld_q) ? sel_q : raw;
  assign wr    = !bus.nWE;
  assign vidwr = cur.vid_pg && wr;

`ifdef CS_ROMWP_EN
  logic wr_q;
  logic bq_q;
  logic err_q;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      wr_q  <= 1'b0;
      bq_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bq_q  <= bus.BACT;
      wr_q  <= bus.BACT && (wr_q || wr);
      err_q <= bq_q && !bus.BACT
            && sel_q.romcs && wr_q;
    end
  end

  assign rom_hit     = sel_q.romcs4x && !wr_q;
  assign rom_blk     = wr;
  assign bus.ROMWERR = err_q;
`else
  assign rom_hit     = sel_q.romcs4x;
  assign rom_blk     = 1'b0;
  assign bus.ROMWERR = 1'b0;
`endif

  assign bus.IOCS       = cur.io_base || vidwr;
  assign bus.IOPWCS     = vidwr;
  assign bus.IACS       = cur.iacs;
  assign bus.ROMCS      = cur.romcs && !rom_blk;
  assign bus.ROMCS4X    = cur.romcs4x && !rom_blk;
  assign bus.RAMCS      = cur.ramcs;
  assign bus.RAMCS0X    = cur.ramcs0x;
  assign bus.SndRAMCSWR = cur.snd_pg && wr && !vidwr;
  assign bus.Overlay    = cur.overlay;

endmodule
